// File: rtl/intersection_sequencer.sv
// Two-road intersection phase controller with a latched pedestrian walk phase.
// Moore FSM; every dwell is counted in tick-enable strobes from the top-level timebase.
module intersection_sequencer #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 8,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int PED_T     = 3,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       side_sensor,
  input  logic       ped_req,
  output logic [1:0] main_light,
  output logic [1:0] side_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_MAIN_GREEN  = 3'd0,
    S_MAIN_YELLOW = 3'd1,
    S_ALLRED_A    = 3'd2,
    S_PED_WALK    = 3'd3,
    S_SIDE_GREEN  = 3'd4,
    S_SIDE_YELLOW = 3'd5,
    S_ALLRED_B    = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] L_GMIN_M1   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] L_GMAX_M1   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] L_YELLOW_M1 = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] L_ALLRED_M1 = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] L_PED_M1    = CNT_W'(PED_T - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_ped_pending;

  state_t           w_next_state;
  logic [CNT_W-1:0] w_next_timer;
  logic             w_hold_timer;
  logic             w_enter_walk;
  logic             w_next_ped;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_MAIN_GREEN;
      r_timer       <= '0;
      r_ped_pending <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_timer       <= w_next_timer;
      r_ped_pending <= w_next_ped;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_timer = r_timer;
    w_hold_timer = 1'b0;
    if (tick) begin
      case (r_state)
        S_MAIN_GREEN: begin
          // Timer saturates so an idle main green can wait forever for demand.
          if (r_timer >= L_GMIN_M1) begin
            w_hold_timer = 1'b1;
            if (side_sensor || r_ped_pending) w_next_state = S_MAIN_YELLOW;
          end
        end
        S_MAIN_YELLOW: if (r_timer == L_YELLOW_M1) w_next_state = S_ALLRED_A;
        S_ALLRED_A: begin
          if (r_timer == L_ALLRED_M1)
            w_next_state = r_ped_pending ? S_PED_WALK : S_SIDE_GREEN;
        end
        S_PED_WALK: begin
          if (r_timer == L_PED_M1)
            w_next_state = side_sensor ? S_SIDE_GREEN : S_ALLRED_B;
        end
        S_SIDE_GREEN: begin
          if ((r_timer >= L_GMIN_M1 && !side_sensor) || r_timer == L_GMAX_M1)
            w_next_state = S_SIDE_YELLOW;
        end
        S_SIDE_YELLOW: if (r_timer == L_YELLOW_M1) w_next_state = S_ALLRED_B;
        S_ALLRED_B:    if (r_timer == L_ALLRED_M1) w_next_state = S_MAIN_GREEN;
        default: ;
      endcase
      if (w_next_state != r_state) w_next_timer = '0;
      else if (!w_hold_timer)      w_next_timer = r_timer + 1'b1;
    end
    // The unused code recovers immediately, without waiting for a tick.
    if (3'(r_state) == 3'd7) begin
      w_next_state = S_MAIN_GREEN;
      w_next_timer = '0;
    end
  end

  assign w_enter_walk = (w_next_state == S_PED_WALK) && (r_state != S_PED_WALK);

  always_comb begin
    w_next_ped = r_ped_pending;
    if (w_enter_walk)                          w_next_ped = 1'b0;
    else if (ped_req && r_state != S_PED_WALK) w_next_ped = 1'b1;
  end

  always_comb begin
    main_light = 2'b00;
    side_light = 2'b00;
    walk       = 1'b0;
    case (r_state)
      S_MAIN_GREEN:  main_light = 2'b01;
      S_MAIN_YELLOW: main_light = 2'b10;
      S_SIDE_GREEN:  side_light = 2'b01;
      S_SIDE_YELLOW: side_light = 2'b10;
      S_PED_WALK:    walk       = 1'b1;
      default: ;
    endcase
  end

  assign ped_pending = r_ped_pending;
  assign phase       = 3'(r_state);

endmodule

// File: tb/tb_intersection_sequencer.sv
// Bench for intersection_sequencer: vector table, directed corner sequences,
// then random stimulus against a dwell-table reference model.
module tb_intersection_sequencer;

  localparam int GMIN   = 4;
  localparam int GMAX   = 8;
  localparam int YEL    = 2;
  localparam int ALLRED = 1;
  localparam int PEDT   = 3;

  logic       clk = 1'b0;
  logic       rst_n, tick, side_sensor, ped_req;
  logic [1:0] main_light, side_light;
  logic       walk, ped_pending;
  logic [2:0] phase;

  intersection_sequencer #(
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YEL),
    .ALLRED_T(ALLRED), .PED_T(PEDT), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .side_sensor(side_sensor),
    .ped_req(ped_req), .main_light(main_light), .side_light(side_light),
    .walk(walk), .ped_pending(ped_pending), .phase(phase)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit rst_n, tick, side, ped;
    int exp_phase;
    bit exp_pp;
  } vec_t;

  vec_t vecs[$];

  // Reference model: phase number, ticks spent in phase, pending flag.
  int m_ph = 0;
  int m_t  = 0;
  bit m_pp = 0;

  function automatic int dwell(input int ph);
    case (ph)
      1, 5:    return YEL;
      2, 6:    return ALLRED;
      3:       return PEDT;
      default: return 1;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit tk, input bit sd, input bit pr);
    int nxt;
    bit leave;
    if (!rst) begin
      m_ph = 0; m_t = 0; m_pp = 0;
      return;
    end
    nxt = m_ph;
    leave = 0;
    if (tk) begin
      if (m_ph == 0) begin
        if (m_t >= GMIN - 1 && (sd || m_pp)) begin leave = 1; nxt = 1; end
      end else if (m_ph == 4) begin
        if ((m_t >= GMIN - 1 && !sd) || m_t == GMAX - 1) begin leave = 1; nxt = 5; end
      end else if (m_t == dwell(m_ph) - 1) begin
        leave = 1;
        if (m_ph == 2)      nxt = m_pp ? 3 : 4;
        else if (m_ph == 3) nxt = sd ? 4 : 6;
        else                nxt = (m_ph + 1) % 7;
      end
      if (leave) m_t = 0;
      else if (!(m_ph == 0 && m_t >= GMIN - 1)) m_t++;
    end
    if (nxt == 3 && m_ph != 3)   m_pp = 0;
    else if (pr && m_ph != 3)    m_pp = 1;
    m_ph = nxt;
  endtask

  // Expected output word {phase, main, side, walk, pending} for a phase.
  function automatic logic [8:0] expect_word(input int ph, input bit pp);
    logic [1:0] ml, sl;
    ml = (ph == 0) ? 2'b01 : (ph == 1) ? 2'b10 : 2'b00;
    sl = (ph == 4) ? 2'b01 : (ph == 5) ? 2'b10 : 2'b00;
    return {3'(ph), ml, sl, (ph == 3), pp};
  endfunction

  function automatic logic [8:0] dut_word();
    return {phase, main_light, side_light, walk, ped_pending};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit tk, input bit sd, input bit pr);
    rst_n = rst; tick = tk; side_sensor = sd; ped_req = pr;
    @(posedge clk);
    model_step(rst, tk, sd, pr);
    #1;
    check("safety", 16'((main_light != 0 && side_light != 0) ||
                        (walk && (main_light != 0 || side_light != 0))), 16'd0);
  endtask

  task automatic add(input bit r, input bit tk, input bit sd, input bit pr,
                     input int ph, input bit pp, input int n);
    vec_t v;
    v.rst_n = r; v.tick = tk; v.side = sd; v.ped = pr;
    v.exp_phase = ph; v.exp_pp = pp;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  initial begin
    bit sd;
    // Idle main green
    add(0,1,0,0, 0,0,1);  add(1,1,0,0, 0,0,20);
    // One-cycle side pulse with saturated timer: side green runs its minimum
    add(1,1,1,0, 1,0,1);  add(1,1,0,0, 1,0,1);  add(1,1,0,0, 2,0,1);
    add(1,1,0,0, 4,0,4);  add(1,1,0,0, 5,0,2);  add(1,1,0,0, 6,0,1);
    add(1,1,0,0, 0,0,10);
    // Pedestrian pulse: walk phase, then all-red straight back to main
    add(1,1,0,1, 0,1,1);  add(1,1,0,0, 1,1,2);  add(1,1,0,0, 2,1,1);
    add(1,1,0,0, 3,0,3);  add(1,1,0,0, 6,0,1);  add(1,1,0,0, 0,0,1);
    // Side sensor held from reset: side green capped at its maximum
    add(0,1,0,0, 0,0,1);  add(1,1,1,0, 0,0,3);  add(1,1,1,0, 1,0,2);
    add(1,1,1,0, 2,0,1);  add(1,1,1,0, 4,0,8);  add(1,1,1,0, 5,0,2);
    add(1,1,1,0, 6,0,1);  add(1,1,1,0, 0,0,1);

    foreach (vecs[i]) begin
      cycle(vecs[i].rst_n, vecs[i].tick, vecs[i].side, vecs[i].ped);
      check($sformatf("vec%0d", i), 16'(dut_word()),
            16'(expect_word(vecs[i].exp_phase, vecs[i].exp_pp)));
    end

    // Tick held low in main yellow: everything frozen, request still latches
    cycle(0,1,0,0);
    for (int k = 0; k < 4; k++) cycle(1,1,1,0);
    check("freeze_entry", 16'(phase), 16'd1);
    for (int k = 0; k < 10; k++) begin
      cycle(1,0,1,(k == 5));
      check("freeze_phase", 16'(phase), 16'd1);
      check("freeze_light", 16'(main_light), 16'd2);
    end
    check("freeze_ped", 16'(ped_pending), 16'd1);
    cycle(1,1,0,0);
    check("resume_t1", 16'(phase), 16'd1);
    cycle(1,1,0,0);
    check("resume_t2", 16'(phase), 16'd2);
    cycle(1,1,0,0);
    check("walk_entry", 16'(dut_word()), 16'(expect_word(3, 0)));

    // Reset mid side-green with a request pending, tick low
    cycle(0,1,0,0);
    for (int k = 0; k < 7; k++) cycle(1,1,1,0);
    check("pre_rst_phase", 16'(phase), 16'd4);
    cycle(1,1,1,1);
    check("pre_rst_ped", 16'(ped_pending), 16'd1);
    cycle(0,0,1,0);
    check("mid_reset", 16'(dut_word()), 16'(expect_word(0, 0)));

    // Random stimulus against the reference model
    sd = 0;
    cycle(0,1,0,0);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) sd = ~sd;
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), sd,
            ($urandom_range(0, 19) == 0));
      check("random", 16'(dut_word()), 16'(expect_word(m_ph, m_pp)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/intersection_sequencer.md
Name: intersection_sequencer

Overview:
Two-road intersection phase controller. It sequences a main road and a side road through green, yellow and all-red phases, and adds a pedestrian walk phase. Decisions come from a side-road car sensor and a latched pedestrian request. All timing counts a tick-enable strobe from the top-level timebase. It sits between the top-level pins (ui_in sensors) and the light outputs (uo_out), and replaces the single-road controller for the intersection build.

Parameters:
GREEN_MIN, 4, minimum green dwell in ticks, for either road
GREEN_MAX, 8, maximum side-road green dwell in ticks
YELLOW_T, 2, yellow dwell in ticks
ALLRED_T, 1, all-red clearance dwell in ticks
PED_T, 3, pedestrian walk dwell in ticks
CNT_W, 4, phase timer width; every dwell parameter must be ≥1 and <2^CNT_W; GREEN_MAX ≥ GREEN_MIN

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
tick  in  1  one-cycle timebase enable; timers advance only when high
side_sensor  in  1  level, high = car waiting or present on the side road
ped_req  in  1  pedestrian button, any width pulse
main_light  out  2  main road light: 00 red, 01 green, 10 yellow (11 never driven)
side_light  out  2  side road light, same encoding
walk  out  1  pedestrian walk lamp
ped_pending  out  1  pedestrian request latched and not yet served
phase  out  3  current state code

Behaviour:
- One clock domain. Reset is synchronous and active-low. All state changes on rising clk.
- Reset values: phase=0 (MAIN_GREEN), timer=0, main_light=01, side_light=00, walk=0, ped_pending=0. Reset asserted mid-operation forces these values on the next edge, regardless of tick.
- The FSM is Moore. Lights, walk and phase decode from the state register, so outputs change on the same edge as the state.
- States and codes: 0 MAIN_GREEN, 1 MAIN_YELLOW, 2 ALLRED_A, 3 PED_WALK, 4 SIDE_GREEN, 5 SIDE_YELLOW, 6 ALLRED_B. Code 7 is illegal and recovers to MAIN_GREEN on the next edge.
- Timer rules:
  - Increments on tick.
  - Clears to 0 on every state transition.
  - Transitions are evaluated only in cycles where tick=1.
  - "Dwell N" means the transition occurs on the tick where timer==N-1.
- Transitions:
  - MAIN_GREEN → MAIN_YELLOW when timer ≥ GREEN_MIN-1 and (side_sensor or ped_pending). Otherwise it stays; the timer saturates at GREEN_MIN-1. Main green with no demand lasts indefinitely.
  - MAIN_YELLOW → ALLRED_A after YELLOW_T.
  - ALLRED_A → PED_WALK after ALLRED_T if ped_pending, else → SIDE_GREEN.
  - PED_WALK → after PED_T: SIDE_GREEN if side_sensor=1 at that tick, else ALLRED_B.
  - SIDE_GREEN → SIDE_YELLOW when (timer ≥ GREEN_MIN-1 and side_sensor=0) or timer==GREEN_MAX-1.
  - SIDE_YELLOW → ALLRED_B after YELLOW_T.
  - ALLRED_B → MAIN_GREEN after ALLRED_T.
- Outputs per state:
  - main_light is 01 only in MAIN_GREEN and 10 only in MAIN_YELLOW.
  - side_light is 01 only in SIDE_GREEN and 10 only in SIDE_YELLOW.
  - walk=1 only in PED_WALK, where both lights are 00.
- Safety invariant: main_light and side_light are never both non-00. walk=1 implies both lights are 00.
- ped_pending rules:
  - Set on any cycle with ped_req=1, tick not required, except while in PED_WALK, where ped_req is ignored.
  - Cleared on the edge entering PED_WALK. If ped_req=1 in that same cycle, clear wins.
- With tick held low, phase and timer are frozen. ped_pending still latches.

Test Plan:
- Reset, then tick=1 every cycle, no inputs, 20 cycles → phase stays 0; main_light=01, side_light=00, walk=0.
- side_sensor held 1 from the first cycle after reset, tick every cycle → 4 cycles phase 0, 2 cycles phase 1, 1 cycle phase 2, 8 cycles phase 4 (capped at GREEN_MAX), 2 cycles phase 5, 1 cycle phase 6, then phase 0.
- side_sensor pulsed 1 for one cycle while in phase 0 with timer saturated → phase 1, 2, then phase 4 for exactly 4 cycles, then 5, 6, 0.
- ped_req one-cycle pulse after 10 idle cycles in phase 0 → ped_pending=1 next cycle; then phase 1 (2 cycles), phase 2 (1 cycle), phase 3 for 3 cycles with walk=1 and both lights 00; ped_pending=0 from PED_WALK entry; then phase 6 (1 cycle), then phase 0.
- tick=0 for 10 cycles while in phase 1 → phase, timer and lights unchanged. A ped_req during that window → ped_pending=1.
- rst_n=0 for one cycle while in phase 4 with ped_pending=1 → next cycle phase=0, main_light=01, side_light=00, ped_pending=0, walk=0.
